// File: rtl/seg_display_pkg.sv
// Shared types, constants and the hex-to-segment decoder for the multiplexed
// seven-segment display slice.
package seg_display_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7f;
    localparam logic [6:0] SEG_DASH = 7'h3f;

    typedef enum logic [1:0] {
        PRE  = 2'd0,
        ON   = 2'd1,
        POST = 2'd2
    } phase_t;

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'ha:    return 7'h08;
            4'hb:    return 7'h03;
            4'hc:    return 7'h27;
            4'hd:    return 7'h21;
            4'he:    return 7'h06;
            default: return 7'h0e;
        endcase
    endfunction

endpackage

// File: rtl/seg_digit_divider.sv
// Sequential restoring divider: value / radix, one quotient bit per cycle.
// Radix 16 takes a single-cycle nibble shortcut.
module seg_digit_divider #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    input  logic [4:0]        radix,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [4:0]        remainder
);

    localparam int unsigned BC_W = $clog2(DATA_W + 1);

    logic [BC_W-1:0] bit_cnt;
    logic [5:0]      trial_c;
    logic            ge_c;
    logic [4:0]      rem_step_c;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial_c    = {remainder, quotient[DATA_W-1]};
        ge_c       = (trial_c >= {1'b0, radix});
        rem_step_c = ge_c ? 5'(trial_c - {1'b0, radix}) : trial_c[4:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            bit_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                if (radix == 5'd16) begin
                    quotient  <= value >> 4;
                    remainder <= {1'b0, value[3:0]};
                    bit_cnt   <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    quotient  <= value;
                    remainder <= '0;
                    bit_cnt   <= BC_W'(DATA_W);
                    busy      <= 1'b1;
                end
            end else if (busy) begin
                quotient  <= {quotient[DATA_W-2:0], ge_c};
                remainder <= rem_step_c;
                bit_cnt   <= bit_cnt - BC_W'(1);
                if (bit_cnt == BC_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment scanner with hex/decimal conversion.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_display
    import seg_display_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned GUARD_CYC = 1024,
    parameter int unsigned ON_CYC    = 14336,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] number,
    input  logic              dec_mode,
    input  logic              blank,
    input  logic [DIGITS-1:0] dp_in,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              frame_done
);

    localparam int unsigned IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FRAME_LEN = DIGITS * (2 * GUARD_CYC + ON_CYC);

    generate
        if (DIGITS * (DATA_W + 1) >= FRAME_LEN) begin : g_bad_cfg
            $error("seg_scan_display: conversion does not fit in one frame");
        end
    endgenerate

    phase_t           phase, phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             frame_start_c;
    logic             frame_end_c;

    logic              conv_active, conv_active_nxt;
    logic              conv_dec, conv_dec_nxt;
    logic [IDX_W-1:0]  conv_digit, conv_digit_nxt;
    logic              ovf, ovf_nxt;
    logic [4:0]        shadow [DIGITS];
    logic [4:0]        shadow_nxt [DIGITS];
    logic [6:0]        disp_buf [DIGITS];
    logic [6:0]        disp_nxt_c [DIGITS];

    logic              div_start_c;
    logic [DATA_W-1:0] div_value_c;
    logic [4:0]        div_radix_c;
    logic              div_busy;
    logic              div_done;
    logic [DATA_W-1:0] div_quot;
    logic [4:0]        div_rem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= PRE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Scan sequencing: PRE guard, ON window, POST guard, then next digit.
    always_comb begin
        phase_nxt     = phase;
        cnt_nxt       = cnt + CNT_W'(1);
        idx_nxt       = idx;
        frame_end_c   = 1'b0;
        frame_start_c = (phase == PRE) && (cnt == '0) && (idx == '0);
        case (phase)
            PRE: begin
                if (cnt == CNT_W'(GUARD_CYC - 1)) begin
                    phase_nxt = ON;
                    cnt_nxt   = '0;
                end
            end
            ON: begin
                if (cnt == CNT_W'(ON_CYC - 1)) begin
                    phase_nxt = POST;
                    cnt_nxt   = '0;
                end
            end
            POST: begin
                if (cnt == CNT_W'(GUARD_CYC - 1)) begin
                    phase_nxt = PRE;
                    cnt_nxt   = '0;
                    if (idx == IDX_W'(DIGITS - 1)) begin
                        idx_nxt     = '0;
                        frame_end_c = 1'b1;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                phase_nxt = PRE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Conversion: snapshot at frame start, then chain DIGITS divisions LSD first.
    always_comb begin
        div_start_c     = 1'b0;
        div_value_c     = div_quot;
        div_radix_c     = conv_dec ? 5'd10 : 5'd16;
        conv_active_nxt = conv_active;
        conv_dec_nxt    = conv_dec;
        conv_digit_nxt  = conv_digit;
        ovf_nxt         = ovf;
        shadow_nxt      = shadow;
        if (frame_start_c) begin
            div_start_c     = 1'b1;
            div_value_c     = number;
            div_radix_c     = dec_mode ? 5'd10 : 5'd16;
            conv_dec_nxt    = dec_mode;
            conv_digit_nxt  = '0;
            conv_active_nxt = 1'b1;
            ovf_nxt         = 1'b0;
        end else if (conv_active && div_done) begin
            shadow_nxt[conv_digit] = div_rem;
            if (conv_digit == IDX_W'(DIGITS - 1)) begin
                conv_active_nxt = 1'b0;
                ovf_nxt         = conv_dec && (div_quot != '0);
            end else begin
                conv_digit_nxt = conv_digit + IDX_W'(1);
                div_start_c    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conv_active <= 1'b0;
            conv_dec    <= 1'b0;
            conv_digit  <= '0;
            ovf         <= 1'b0;
            for (int i = 0; i < int'(DIGITS); i++) shadow[i] <= '0;
        end else begin
            conv_active <= conv_active_nxt;
            conv_dec    <= conv_dec_nxt;
            conv_digit  <= conv_digit_nxt;
            ovf         <= ovf_nxt;
            shadow      <= shadow_nxt;
        end
    end

    seg_digit_divider #(
        .DATA_W(DATA_W)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start_c),
        .value     (div_value_c),
        .radix     (div_radix_c),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    // Segment image for the buffer copy; the in-flight last digit is bypassed in.
    always_comb begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
        logic lead;
        lead = 1'b1;
`endif
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (ovf_nxt || (shadow_nxt[i] > 5'd15)) begin
                disp_nxt_c[i] = SEG_DASH;
            end else begin
                disp_nxt_c[i] = hex_to_seg(shadow_nxt[i][3:0]);
            end
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (!ovf_nxt && lead && (i != 0) && (shadow_nxt[i] == 5'd0)) begin
                disp_nxt_c[i] = SEG_OFF;
            end
            if (shadow_nxt[i] != 5'd0) begin
                lead = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DIGITS); i++) disp_buf[i] <= SEG_OFF;
        end else if (frame_end_c && !conv_active_nxt && !div_busy) begin
            disp_buf <= disp_nxt_c;
        end
    end

    // Outputs registered from the next scan state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= (phase_nxt == ON) ? ~(DIGITS'(1) << idx_nxt) : '1;
            seg        <= ((phase_nxt == ON) && !blank) ? disp_buf[idx_nxt] : SEG_OFF;
            dp         <= !((phase_nxt == ON) && !blank && dp_in[idx_nxt]);
            frame_done <= frame_end_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: frame-level behavioural model checked every cycle,
// plus directed literal checks of the test-plan scenarios.
module tb_seg_scan_display;

    localparam int G     = 2;
    localparam int ONC   = 16;
    localparam int SLOT  = 2 * G + ONC;
    localparam int FRAME = 4 * SLOT;

    logic        clk;
    logic        reset_n;
    logic [15:0] number;
    logic        dec_mode;
    logic        blank;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    seg_scan_display #(
        .DIGITS(4), .DATA_W(16), .GUARD_CYC(G), .ON_CYC(ONC), .CNT_W(16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .number     (number),
        .dec_mode   (dec_mode),
        .blank      (blank),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0e};

    // What a snapshot of (n, dm) should look like on the four digits.
    function automatic logic [3:0][6:0] model_digits(input logic [15:0] n, input logic dm);
        logic [3:0][6:0] r;
        int v, p10, hi, dig;
        v   = int'(n);
        p10 = 1;
        hi  = 0;
        if (dm && v >= 10000) begin
            for (int i = 0; i < 4; i++) r[i] = 7'h3f;
            return r;
        end
        for (int i = 0; i < 4; i++) begin
            dig  = dm ? (v / p10) % 10 : (v >> (4 * i)) & 15;
            p10  = p10 * 10;
            if (dig != 0) hi = i;
            r[i] = segtab[dig];
        end
`ifdef SEG_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < 4; i++) if (i > hi) r[i] = 7'h7f;
`endif
        return r;
    endfunction

    int              t;
    logic [3:0][6:0] disp_m, pend_m;
    logic            blank_q;
    logic [3:0]      dp_q;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t       <= 0;
            disp_m  <= {4{7'h7f}};
            pend_m  <= {4{7'h7f}};
            blank_q <= 1'b0;
            dp_q    <= 4'b0;
        end else begin
            if (t % FRAME == 0) begin
                disp_m <= pend_m;
                pend_m <= model_digits(number, dec_mode);
            end
            blank_q <= blank;
            dp_q    <= dp_in;
            t       <= t + 1;
        end
    end

    int         m_p, m_d, m_q;
    logic       m_on;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e, fd_e;

    always @(negedge clk) begin
        if (reset_n) begin
            m_p   = t % FRAME;
            m_d   = m_p / SLOT;
            m_q   = m_p % SLOT;
            m_on  = (m_q >= G) && (m_q < G + ONC);
            an_e  = m_on ? ~(4'b0001 << m_d) : 4'hf;
            seg_e = (m_on && !blank_q) ? disp_m[m_d] : 7'h7f;
            dp_e  = !(m_on && !blank_q && dp_q[m_d]);
            fd_e  = (m_p == 0) && (t != 0);
            n_vec++;
            if (an !== an_e || seg !== seg_e || dp !== dp_e || frame_done !== fd_e) begin
                n_err++;
                $display("FAIL cycle t=%0d: an=%b seg=%h dp=%b fd=%b, expected an=%b seg=%h dp=%b fd=%b",
                         t, an, seg, dp, frame_done, an_e, seg_e, dp_e, fd_e);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] an_x, input logic [6:0] seg_x,
                       input logic dp_x);
        n_vec++;
        if (an !== an_x || seg !== seg_x || dp !== dp_x) begin
            n_err++;
            $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                     name, an, seg, dp, an_x, seg_x, dp_x);
        end
    endtask

    task automatic chk_fd(input string name, input logic fd_x);
        n_vec++;
        if (frame_done !== fd_x) begin
            n_err++;
            $display("FAIL %s: got frame_done=%b, expected %b", name, frame_done, fd_x);
        end
    endtask

    task automatic wait_t(input int target);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (t != target && guard < 4000);
        if (t != target) begin
            n_err++;
            $display("FAIL wait_t: t=%0d, expected %0d", t, target);
            $fatal(1, "bench timeout");
        end
        #1;
    endtask

    task automatic reset_with(input logic [15:0] n, input logic dm);
        reset_n  = 1'b0;
        number   = n;
        dec_mode = dm;
        blank    = 1'b0;
        dp_in    = 4'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", 4'hf, 7'h7f, 1'b1);
        chk_fd("reset_fd", 1'b0);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;

        // Hex 0x1234: second frame shows 4,3,2,1.
        reset_with(16'h1234, 1'b0);
        wait_t(80);      chk_fd("fd_pulse", 1'b1);
        wait_t(81);      chk_fd("fd_low", 1'b0);
        wait_t(80 + 9);  chk("hex_d0", 4'b1110, 7'h19, 1'b1);
        wait_t(80 + 29); chk("hex_d1", 4'b1101, 7'h30, 1'b1);
        wait_t(80 + 49); chk("hex_d2", 4'b1011, 7'h24, 1'b1);
        wait_t(80 + 69); chk("hex_d3", 4'b0111, 7'h79, 1'b1);
        wait_t(80 + 79); chk("hex_gap", 4'b1111, 7'h7f, 1'b1);

        // Decimal 9876.
        reset_with(16'd9876, 1'b1);
        wait_t(80 + 9);  chk("dec_d0", 4'b1110, 7'h02, 1'b1);
        wait_t(80 + 29); chk("dec_d1", 4'b1101, 7'h78, 1'b1);
        wait_t(80 + 49); chk("dec_d2", 4'b1011, 7'h00, 1'b1);
        wait_t(80 + 69); chk("dec_d3", 4'b0111, 7'h10, 1'b1);
        wait_t(160);     chk_fd("dec_fd", 1'b1);

        // Decimal overflow, then 42 two frames later.
        reset_with(16'd10000, 1'b1);
        wait_t(80 + 9);  chk("ovf_d0", 4'b1110, 7'h3f, 1'b1);
        wait_t(80 + 69); chk("ovf_d3", 4'b0111, 7'h3f, 1'b1);
        wait_t(150);     number = 16'd42;
        wait_t(160 + 29); chk("ovf_hold", 4'b1101, 7'h3f, 1'b1);
        wait_t(240 + 9);  chk("d42_d0", 4'b1110, 7'h24, 1'b1);
        wait_t(240 + 29); chk("d42_d1", 4'b1101, 7'h19, 1'b1);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        wait_t(240 + 49); chk("d42_d2", 4'b1011, 7'h7f, 1'b1);
        wait_t(240 + 69); chk("d42_d3", 4'b0111, 7'h7f, 1'b1);
`else
        wait_t(240 + 49); chk("d42_d2", 4'b1011, 7'h40, 1'b1);
        wait_t(240 + 69); chk("d42_d3", 4'b0111, 7'h40, 1'b1);
`endif

        // Mid-frame toggle 0x1111 -> 0x2222.
        reset_with(16'h1111, 1'b0);
        wait_t(80 + 30); number = 16'h2222;
        wait_t(80 + 69);  chk("tog_cur", 4'b0111, 7'h79, 1'b1);
        wait_t(160 + 9);  chk("tog_next", 4'b1110, 7'h79, 1'b1);
        wait_t(240 + 29); chk("tog_after", 4'b1101, 7'h24, 1'b1);

        // Asynchronous reset inside an ON window.
        wait_t(240 + 49);
        reset_n = 1'b0;
        #1 chk("reset_async", 4'b1111, 7'h7f, 1'b1);
        chk_fd("reset_async_fd", 1'b0);
        reset_with(16'h5555, 1'b0);
        wait_t(9);       chk("post_reset_blank", 4'b1110, 7'h7f, 1'b1);
        wait_t(80 + 9);  chk("post_reset_val", 4'b1110, 7'h12, 1'b1);

        // Blank overrides digits and dp; dp then shows on digit 2 only.
        reset_with(16'h0000, 1'b0);
        blank = 1'b1;
        dp_in = 4'b0100;
        wait_t(80 + 47);  chk("blank_d2", 4'b1011, 7'h7f, 1'b1);
        wait_t(160);      blank = 1'b0;
        wait_t(160 + 9);  chk("unblank_d0", 4'b1110, 7'h40, 1'b1);
        wait_t(160 + 47); chk("unblank_d2", 4'b1011, 7'h40, 1'b0);

        // Decimal 7: leading digits depend on the build option.
        reset_with(16'd7, 1'b1);
        wait_t(80 + 9);  chk("dec7_d0", 4'b1110, 7'h78, 1'b1);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        wait_t(80 + 29); chk("dec7_d1", 4'b1101, 7'h7f, 1'b1);
        wait_t(80 + 69); chk("dec7_d3", 4'b0111, 7'h7f, 1'b1);
`else
        wait_t(80 + 29); chk("dec7_d1", 4'b1101, 7'h40, 1'b1);
        wait_t(80 + 69); chk("dec7_d3", 4'b0111, 7'h40, 1'b1);
`endif
        wait_t(160 + 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
